serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/full_adder.sv | 22 ++
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_arith_pkg                                                     |
// | Shared constants and FSM state encoding for the serial arithmetic    |
// | blocks.                                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_arith_pkg;

    localparam int c_DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serial_state_t;

endpackage : serial_arith_pkg
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | full_adder                                                           |
// | Single-bit combinational full adder cell.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module full_adder (
    input  logic X,
    input  logic Y,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic w_xy;

    assign w_xy = X ^ Y;
    assign Sum  = w_xy ^ Cin;
    assign Cout = (X & Y) | (Cin & w_xy);

endmodule : full_adder
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor                                                    |
// | Bit-serial A-B (as A + ~B + 1), LSB first, with unsigned borrow and  |
// | signed overflow flags.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam int              c_CW   = $clog2(WIDTH) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    serial_state_t    r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [c_CW-1:0]  r_cnt;
    logic             r_carry;
    logic             r_cin_msb;

    logic             w_b_inv;
    logic             w_sum;
    logic             w_cout;

    assign w_b_inv = ~r_b[0];

    full_adder u_cell (
        .X    (r_a[0]),
        .Y    (w_b_inv),
        .Cin  (r_carry),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
            Ovf       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_carry <= 1'b1;
                        Busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + c_ONE;
                    // On the MSB cycle the current carry is the carry into the sign bit.
                    if (r_cnt == c_LAST) begin
                        r_cin_msb <= r_carry;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Done    <= 1'b1;
                    Diff    <= r_res;
                    Bout    <= ~r_carry;
                    Ovf     <= r_cin_msb ^ r_carry;
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor                                                 |
// | Self-checking bench: directed corner cases plus random operands      |
// | compared against an arithmetic reference model.                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

    localparam int c_W     = 16;
    localparam int c_LIMIT = 3 * c_W;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic [c_W-1:0] diff;
    logic           bout;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(c_W)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .Start (start),
        .A     (a),
        .B     (b),
        .Busy  (busy),
        .Done  (done),
        .Diff  (diff),
        .Bout  (bout),
        .Ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, unsigned compare and signed range test.
    task automatic model(input logic [c_W-1:0] ma, input logic [c_W-1:0] mb,
                         output logic [c_W-1:0] md, output logic mbo, output logic mov);
        int sd;
        md  = c_W'(int'(ma) - int'(mb));
        mbo = (int'(ma) < int'(mb));
        sd  = int'($signed(ma)) - int'($signed(mb));
        mov = (sd > 32767) || (sd < -32768);
    endtask

    // Counts edges (sampled 1 time unit after each) until Done, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < c_LIMIT) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
    endtask

    task automatic check_result(input string tag, input int n,
                                input logic [c_W-1:0] ed, input logic eb, input logic eo);
        check({tag, "_latency"}, n, c_W + 1);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    task automatic run_op(input string tag, input logic [c_W-1:0] oa, input logic [c_W-1:0] ob);
        logic [c_W-1:0] ed;
        logic eb, eo;
        int n;
        model(oa, ob, ed, eb, eo);
        @(negedge clk);
        start = 1'b1;
        a = oa;
        b = ob;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = c_W'($urandom);
        b = c_W'($urandom);
        check({tag, "_busy_run"}, busy, 1'b1);
        wait_done(n);
        check_result(tag, n, ed, eb, eo);
        check({tag, "_busy_after"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, done, 1'b0);
        check({tag, "_diff_hold"}, diff, ed);
    endtask

    initial begin
        int n;
        logic [c_W-1:0] ra, rb;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_diff", diff, 16'h0000);
        check("reset_bout", bout, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("small_pos", 16'h0005, 16'h0003);
        run_op("borrow", 16'h0003, 16'h0005);
        run_op("signed_ovf", 16'h8000, 16'h0001);
        run_op("equal_ff", 16'hFFFF, 16'hFFFF);
        run_op("pos_minus_neg", 16'h7FFF, 16'hFFFF);

        // Start held high through a run: one Done, second request taken only from IDLE.
        @(negedge clk);
        start = 1'b1;
        a = 16'h1234;
        b = 16'h0034;
        @(posedge clk);
        #1;
        a = 16'hFFFF;
        b = 16'h0000;
        wait_done(n);
        check_result("held_first", n, 16'h1200, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_accept_busy", busy, 1'b1);
        check("held_no_done", done, 1'b0);
        wait_done(n);
        check_result("held_second", n, 16'hFFFF, 1'b0, 1'b0);

        // Reset in the middle of the run, with bit 8 in flight.
        @(negedge clk);
        start = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_diff", diff, 16'h0000);
        check("rst_mid_bout", bout, 1'b0);
        check("rst_mid_ovf", ovf, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold_done", done, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op("after_reset", 16'h0010, 16'h0001);

        for (int i = 0; i < 20; i++) begin
            ra = c_W'($urandom);
            rb = (i % 5 == 0) ? ra : c_W'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_subtractor
`default_nettype wire
